// File: rtl/afe_serial_arbiter.sv
// afe_serial_arbiter: round-robin sharing of the AFE serial transaction engine between command sources.
// Optional wait-state watchdog is compiled in when AFE_ARB_TIMEOUT_EN is defined.
module afe_serial_arbiter #(
   parameter int NUM_REQ        = 3,
   parameter int CMD_WIDTH      = 20,
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_REQ-1:0]           req,
   input  logic [NUM_REQ*CMD_WIDTH-1:0] req_command,
   output logic [NUM_REQ-1:0]           grant,
   output logic [NUM_REQ-1:0]           ack,
   input  logic                         serial_ready,
   output logic [CMD_WIDTH-1:0]         afe_command,
   output logic                         start_transaction,
   output logic                         busy,
   output logic                         timeout_err
);

   localparam int IDX_W = $clog2(NUM_REQ);

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_LAUNCH    = 3'd1;
   localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
   localparam logic [2:0] ST_WAIT_DONE = 3'd3;
   localparam logic [2:0] ST_ACK       = 3'd4;

   localparam logic [IDX_W:0]       NUM_REQ_W = (IDX_W+1)'(NUM_REQ);
   localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(NUM_REQ - 1);
   localparam logic [NUM_REQ-1:0]   ONE       = NUM_REQ'(1);

   if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
      $error("afe_serial_arbiter: NUM_REQ must be in 2..8");
   end
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("afe_serial_arbiter: TIMEOUT_CYCLES must be in 1..65535");
   end

   logic [2:0]           state;
   logic [IDX_W-1:0]     ptr;
   logic [IDX_W-1:0]     idx;
   logic [IDX_W-1:0]     win_idx;
   logic                 win_found;
   logic [IDX_W:0]       probe;
   logic [CMD_WIDTH-1:0] win_cmd;
   logic                 timeout_hit;

   // Scan upward from the pointer, wrapping, so the first set request after the last winner is served.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      probe     = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         probe = {1'b0, ptr} + (IDX_W+1)'(k);
         if (probe >= NUM_REQ_W) begin
            probe = probe - NUM_REQ_W;
         end
         if (!win_found && req[probe[IDX_W-1:0]]) begin
            win_found = 1'b1;
            win_idx   = probe[IDX_W-1:0];
         end
      end
   end

   always_comb begin
      win_cmd = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_idx == IDX_W'(i)) begin
            win_cmd = req_command[i*CMD_WIDTH +: CMD_WIDTH];
         end
      end
   end

`ifdef AFE_ARB_TIMEOUT_EN
   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] wait_cnt;
   logic        in_wait;
   logic        wait_exit;

   assign in_wait     = (state == ST_WAIT_BUSY) || (state == ST_WAIT_DONE);
   assign wait_exit   = ((state == ST_WAIT_BUSY) && !serial_ready) ||
                        ((state == ST_WAIT_DONE) &&  serial_ready);
   assign timeout_hit = in_wait && !wait_exit && (wait_cnt == TIMEOUT_LAST);

   // The count restarts whenever a wait state is entered, so each wait phase gets the full budget.
   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt    <= '0;
         timeout_err <= 1'b0;
      end else begin
         if (in_wait && !wait_exit) begin
            wait_cnt <= wait_cnt + 16'd1;
         end else begin
            wait_cnt <= '0;
         end
         if (timeout_hit) begin
            timeout_err <= 1'b1;
         end
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign timeout_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state             <= ST_IDLE;
         ptr               <= '0;
         idx               <= '0;
         grant             <= '0;
         ack               <= '0;
         afe_command       <= '0;
         start_transaction <= 1'b0;
         busy              <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (serial_ready && win_found) begin
                  state             <= ST_LAUNCH;
                  idx               <= win_idx;
                  grant             <= ONE << win_idx;
                  afe_command       <= win_cmd;
                  start_transaction <= 1'b1;
                  busy              <= 1'b1;
               end
            end
            ST_LAUNCH: begin
               start_transaction <= 1'b0;
               state             <= ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
               if (!serial_ready) begin
                  state <= ST_WAIT_DONE;
               end else if (timeout_hit) begin
                  state <= ST_ACK;
                  ack   <= grant;
               end
            end
            ST_WAIT_DONE: begin
               if (serial_ready || timeout_hit) begin
                  state <= ST_ACK;
                  ack   <= grant;
               end
            end
            ST_ACK: begin
               state       <= ST_IDLE;
               ack         <= '0;
               grant       <= '0;
               afe_command <= '0;
               busy        <= 1'b0;
               ptr         <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
            end
            default: begin
               state             <= ST_IDLE;
               grant             <= '0;
               ack               <= '0;
               afe_command       <= '0;
               start_transaction <= 1'b0;
               busy              <= 1'b0;
            end
         endcase
      end
   end

   a_grant_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(grant));
   a_ack_onehot:   assert property (@(posedge clk) disable iff (reset) $onehot0(ack));
   a_start_pulse:  assert property (@(posedge clk) disable iff (reset)
                                    start_transaction |=> !start_transaction);

endmodule

// File: tb/tb_afe_serial_arbiter.sv
// Directed bench for afe_serial_arbiter: per-cycle comparison against a transaction-level model
// plus literal expectations; build with AFE_ARB_TIMEOUT_EN to exercise the watchdog.
module tb_afe_serial_arbiter;

   localparam int N  = 3;
   localparam int CW = 20;
   localparam int TO = 16;
`ifdef AFE_ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [N-1:0]    req = '0;
   logic [N*CW-1:0] req_command = '0;
   logic            serial_ready = 1'b1;
   logic [N-1:0]    grant;
   logic [N-1:0]    ack;
   logic [CW-1:0]   afe_command;
   logic            start_transaction;
   logic            busy;
   logic            timeout_err;

   int checks   = 0;
   int failures = 0;
   bit check_en = 1'b0;

   always #5 clk = ~clk;

   afe_serial_arbiter #(
      .NUM_REQ(N),
      .CMD_WIDTH(CW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk),
      .reset(reset),
      .req(req),
      .req_command(req_command),
      .grant(grant),
      .ack(ack),
      .serial_ready(serial_ready),
      .afe_command(afe_command),
      .start_transaction(start_transaction),
      .busy(busy),
      .timeout_err(timeout_err)
   );

   task automatic check_output(string name, logic [31:0] actual, logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic int pick_winner(logic [N-1:0] r, int p);
      for (int k = 0; k < N; k++) begin
         if (r[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   function automatic logic [31:0] onehot(int i);
      return (i < 0) ? 32'd0 : (32'd1 << i);
   endfunction

   // Model: who is being served, whether the launch cycle is current, whether the engine has gone busy.
   int            m_cur = -1;
   int            m_ptr = 0;
   int            m_wait = 0;
   bit            m_fresh = 1'b0;
   bit            m_low = 1'b0;
   bit            m_acking = 1'b0;
   bit            m_terr = 1'b0;
   logic [CW-1:0] m_cmd = '0;

   always @(posedge clk) begin
      if (reset) begin
         m_cur    <= -1;
         m_ptr    <= 0;
         m_wait   <= 0;
         m_fresh  <= 1'b0;
         m_low    <= 1'b0;
         m_acking <= 1'b0;
         m_terr   <= 1'b0;
         m_cmd    <= '0;
      end else if (m_cur < 0) begin
         if (serial_ready && req != '0) begin
            m_cur    <= pick_winner(req, m_ptr);
            m_cmd    <= req_command[pick_winner(req, m_ptr)*CW +: CW];
            m_fresh  <= 1'b1;
            m_low    <= 1'b0;
            m_acking <= 1'b0;
            m_wait   <= 0;
         end
      end else if (m_acking) begin
         m_ptr    <= (m_cur + 1) % N;
         m_cur    <= -1;
         m_acking <= 1'b0;
      end else if (m_fresh) begin
         m_fresh <= 1'b0;
      end else if (m_low ? serial_ready : !serial_ready) begin
         if (m_low) m_acking <= 1'b1;
         else m_low <= 1'b1;
         m_wait <= 0;
      end else if (TO_EN && (m_wait + 1 == TO)) begin
         m_acking <= 1'b1;
         m_terr   <= 1'b1;
      end else begin
         m_wait <= m_wait + 1;
      end
   end

   always @(negedge clk) begin
      if (check_en) begin
         check_output("grant", 32'(grant), onehot(m_cur));
         check_output("ack", 32'(ack), m_acking ? onehot(m_cur) : 32'd0);
         check_output("start_transaction", 32'(start_transaction), 32'(m_cur >= 0 && m_fresh));
         check_output("busy", 32'(busy), 32'(m_cur >= 0));
         check_output("afe_command", 32'(afe_command), (m_cur >= 0) ? 32'(m_cmd) : 32'd0);
         check_output("timeout_err", 32'(timeout_err), 32'(m_terr));
      end
   end

   task automatic step(int n = 1);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic apply_stimulus(logic [N-1:0] r, logic rdy);
      req          = r;
      serial_ready = rdy;
   endtask

   task automatic run_engine(int low);
      serial_ready = 1'b0;
      step(low);
      serial_ready = 1'b1;
   endtask

   task automatic wait_start(string name, logic [N-1:0] exp_grant, output int n);
      n = 0;
      while (!start_transaction && n < 60) begin
         step();
         n++;
      end
      check_output({name, "_launched"}, 32'(start_transaction), 32'd1);
      check_output({name, "_grant"}, 32'(grant), 32'(exp_grant));
   endtask

   task automatic wait_ack(string name, logic [N-1:0] exp_ack, output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (ack == '0 && n < 100);
      check_output({name, "_ack"}, 32'(ack), 32'(exp_ack));
   endtask

   logic [CW-1:0] cmds [N];
   int order [6] = '{0, 1, 2, 0, 1, 2};
   int n;

   initial begin
      cmds[0] = 20'h11111;
      cmds[1] = 20'h22222;
      cmds[2] = 20'h33333;

      reset = 1'b1;
      step();
      check_en = 1'b1;
      step();
      check_output("reset_grant", 32'(grant), 32'd0);
      check_output("reset_busy", 32'(busy), 32'd0);
      check_output("reset_command", 32'(afe_command), 32'd0);
      reset = 1'b0;

      $display("[TB] single requester");
      req_command[1*CW +: CW] = 20'h1A5C3;
      apply_stimulus(3'b010, 1'b1);
      step();
      check_output("single_start", 32'(start_transaction), 32'd1);
      check_output("single_grant", 32'(grant), 32'h2);
      check_output("single_command", 32'(afe_command), 32'h1A5C3);
      serial_ready = 1'b0;
      step();
      check_output("single_start_width", 32'(start_transaction), 32'd0);
      step(2);
      check_output("single_no_early_ack", 32'(ack), 32'd0);
      serial_ready = 1'b1;
      step();
      check_output("single_ack", 32'(ack), 32'h2);
      req = '0;
      step();
      check_output("single_ack_width", 32'(ack), 32'd0);
      check_output("single_idle_command", 32'(afe_command), 32'd0);

      $display("[TB] ready held low in idle");
      req_command[0 +: CW] = 20'h00F0F;
      apply_stimulus(3'b001, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step();
         check_output("blocked_start", 32'(start_transaction), 32'd0);
         check_output("blocked_busy", 32'(busy), 32'd0);
      end
      serial_ready = 1'b1;
      wait_start("blocked", 3'b001, n);
      check_output("blocked_launch_latency", 32'(n), 32'd1);
      run_engine(2);
      wait_ack("blocked", 3'b001, n);
      check_output("blocked_ack_latency", 32'(n), 32'd1);
      req = '0;
      step();

      $display("[TB] round robin from reset");
      for (int i = 0; i < N; i++) req_command[i*CW +: CW] = cmds[i];
      reset = 1'b1;
      step();
      reset = 1'b0;
      apply_stimulus(3'b111, 1'b1);
      for (int i = 0; i < 6; i++) begin
         wait_start("rr", N'(onehot(order[i])), n);
         if (i > 0) check_output("rr_relaunch_gap", 32'(n), 32'd2);
         check_output("rr_command", 32'(afe_command), 32'(cmds[order[i]]));
         run_engine(2);
         wait_ack("rr", N'(onehot(order[i])), n);
      end
      req = '0;
      step();

      $display("[TB] request dropped during transaction");
      apply_stimulus(3'b100, 1'b1);
      wait_start("drop", 3'b100, n);
      req = 3'b101;
      serial_ready = 1'b0;
      step(2);
      req = 3'b001;
      serial_ready = 1'b1;
      wait_ack("drop", 3'b100, n);
      wait_start("drop_next", 3'b001, n);
      run_engine(2);
      wait_ack("drop_next", 3'b001, n);
      req = '0;
      step();

      $display("[TB] reset mid-transaction");
      apply_stimulus(3'b011, 1'b1);
      wait_start("rst", 3'b010, n);
      serial_ready = 1'b0;
      step(2);
      reset = 1'b1;
      step();
      check_output("rst_grant", 32'(grant), 32'd0);
      check_output("rst_ack", 32'(ack), 32'd0);
      check_output("rst_busy", 32'(busy), 32'd0);
      check_output("rst_command", 32'(afe_command), 32'd0);
      reset = 1'b0;
      serial_ready = 1'b1;
      wait_start("after_rst", 3'b001, n);
      run_engine(2);
      wait_ack("after_rst", 3'b001, n);
      req = '0;
      step();

      $display("[TB] ready stuck low after launch");
      apply_stimulus(3'b001, 1'b1);
      wait_start("stuck", 3'b001, n);
      serial_ready = 1'b0;
`ifdef AFE_ARB_TIMEOUT_EN
      wait_ack("stuck", 3'b001, n);
      check_output("stuck_ack_latency", 32'(n), 32'd18);
      check_output("stuck_timeout_err", 32'(timeout_err), 32'd1);
      req = '0;
      step(5);
      check_output("stuck_err_sticky", 32'(timeout_err), 32'd1);
      check_output("stuck_idle", 32'(busy), 32'd0);
      reset = 1'b1;
      step();
      check_output("stuck_err_cleared", 32'(timeout_err), 32'd0);
      reset = 1'b0;
`else
      step(40);
      check_output("stuck_busy", 32'(busy), 32'd1);
      check_output("stuck_no_ack", 32'(ack), 32'd0);
      check_output("stuck_timeout_err", 32'(timeout_err), 32'd0);
      req = '0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_output("stuck_reset_busy", 32'(busy), 32'd0);
`endif
      serial_ready = 1'b1;
      step(2);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL global_timeout: simulation did not complete, got %0d checks, required completion", checks);
      $fatal(1, "[TB] simulation time limit reached");
   end

endmodule
